// File: rtl/md5_accel_pkg.sv
// Shared widths, collector state encoding and small helpers for the MD5 candidate-search datapath.
package md5_accel_pkg;

    localparam int DIGEST_W = 128;
    localparam int CAND_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } collector_state_t;

    // Hit counter holds at all-ones rather than wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; simultaneous push and pop succeed even when full.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !srst) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    // Head shows zero while empty so a stale word is never presented.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/md5_result_collector.sv
// Pairs issued candidates with returned digests, compares against the target and
// queues matching candidates for software, tracking scan progress and sequencing errors.
module md5_result_collector
    import md5_accel_pkg::*;
#(
    parameter int MAX_INFLIGHT = 64,
    parameter int HIT_DEPTH    = 4
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                start,
    input  logic [DIGEST_W-1:0] target,
    input  logic                cand_valid,
    input  logic [CAND_W-1:0]   cand_value,
    input  logic                src_done,
    input  logic                digest_valid,
    input  logic [DIGEST_W-1:0] digest,
    input  logic                hit_rd,
    output logic [CAND_W-1:0]   hit_value,
    output logic                hit_empty,
    output logic [15:0]         hit_total,
    output logic                overflow,
    output logic                seq_err,
    output logic                busy,
    output logic                done
);

    localparam int LANES = DIGEST_W / 32;

    collector_state_t    state_reg;
    logic [DIGEST_W-1:0] target_reg;
    logic [15:0]         hit_total_reg;
    logic                overflow_reg;
    logic                seq_err_reg;
    logic                busy_reg;
    logic                done_reg;

    logic                start_ok;
    logic                active;
    logic                tag_push;
    logic                tag_pop;
    logic                tag_full;
    logic                tag_empty;
    logic [CAND_W-1:0]   tag_head;
    logic                hit_full;
    logic [LANES-1:0]    lane_eq;
    logic                match;
    logic                tag_overrun;
    logic                stray_digest;
    logic                hit_drop;

    assign start_ok = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign active   = (state_reg == ST_SCAN) || (state_reg == ST_DRAIN);
    assign tag_push = cand_valid && (state_reg == ST_SCAN);
    assign tag_pop  = digest_valid && active && !tag_empty;

    // Compare split into 32-bit lanes to keep each equality tree shallow.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_cmp
            assign lane_eq[gi] = (digest[gi*32 +: 32] == target_reg[gi*32 +: 32]);
        end
    endgenerate

    assign match        = tag_pop && (&lane_eq);
    assign tag_overrun  = tag_push && tag_full && !tag_pop;
    assign stray_digest = digest_valid && active && tag_empty;
    // A full hit FIFO still accepts the match if the head is read in the same cycle.
    assign hit_drop     = match && hit_full && !hit_rd;

    sync_fifo #(
        .WIDTH (CAND_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk     (CLK),
        .srst    (reset),
        .flush   (start_ok),
        .push    (tag_push),
        .pop     (tag_pop),
        .wr_data (cand_value),
        .rd_data (tag_head),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    sync_fifo #(
        .WIDTH (CAND_W),
        .DEPTH (HIT_DEPTH)
    ) u_hit_fifo (
        .clk     (CLK),
        .srst    (reset),
        .flush   (start_ok),
        .push    (match),
        .pop     (hit_rd),
        .wr_data (tag_head),
        .rd_data (hit_value),
        .full    (hit_full),
        .empty   (hit_empty)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            target_reg    <= '0;
            hit_total_reg <= '0;
            overflow_reg  <= 1'b0;
            seq_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else if (start_ok) begin
            state_reg     <= ST_SCAN;
            target_reg    <= target;
            hit_total_reg <= '0;
            overflow_reg  <= 1'b0;
            seq_err_reg   <= 1'b0;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            if (match) begin
                hit_total_reg <= sat_inc16(hit_total_reg);
            end
            overflow_reg <= overflow_reg | hit_drop;
            seq_err_reg  <= seq_err_reg | tag_overrun | stray_digest;
            case (state_reg)
                ST_SCAN: begin
                    if (src_done) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (tag_empty && !digest_valid) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hit_total = hit_total_reg;
    assign overflow  = overflow_reg;
    assign seq_err   = seq_err_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_md5_result_collector.sv
// Directed and randomized bench for md5_result_collector against a queue-based reference model.
module tb_md5_result_collector;

    localparam int P_IDLE  = 0;
    localparam int P_SCAN  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;
    localparam int INFL    = 64;
    localparam int HDEPTH  = 4;

    logic         CLK = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] target;
    logic         cand_valid;
    logic [31:0]  cand_value;
    logic         src_done;
    logic         digest_valid;
    logic [127:0] digest;
    logic         hit_rd;
    logic [31:0]  hit_value;
    logic         hit_empty;
    logic [15:0]  hit_total;
    logic         overflow;
    logic         seq_err;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int           m_phase = P_IDLE;
    logic [31:0]  m_tags[$];
    logic [31:0]  m_hits[$];
    int           m_total = 0;
    bit           m_ovf = 1'b0;
    bit           m_serr = 1'b0;
    logic [127:0] m_tgt = '0;

    always #5 CLK = ~CLK;

    md5_result_collector #(
        .MAX_INFLIGHT (INFL),
        .HIT_DEPTH    (HDEPTH)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .start        (start),
        .target       (target),
        .cand_valid   (cand_valid),
        .cand_value   (cand_value),
        .src_done     (src_done),
        .digest_valid (digest_valid),
        .digest       (digest),
        .hit_rd       (hit_rd),
        .hit_value    (hit_value),
        .hit_empty    (hit_empty),
        .hit_total    (hit_total),
        .overflow     (overflow),
        .seq_err      (seq_err),
        .busy         (busy),
        .done         (done)
    );

    // Stand-in for the MD5 core: any injective value-to-digest map will do.
    function automatic logic [127:0] fmd5(input logic [31:0] v);
        return {v * 32'h9E3779B1, ~v, v ^ 32'hA5A5A5A5, v + 32'h01234567};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int          nt;
        int          nh;
        bit          act;
        bit          pop_ok;
        bit          rd;
        logic [31:0] popped;
        nt     = m_tags.size();
        nh     = m_hits.size();
        act    = (m_phase == P_SCAN) || (m_phase == P_DRAIN);
        pop_ok = 1'b0;
        popped = '0;
        if (reset) begin
            m_phase = P_IDLE; m_tags.delete(); m_hits.delete();
            m_total = 0; m_ovf = 1'b0; m_serr = 1'b0; m_tgt = '0;
            return;
        end
        if (start && (m_phase == P_IDLE || m_phase == P_DONE)) begin
            m_phase = P_SCAN; m_tgt = target; m_tags.delete(); m_hits.delete();
            m_total = 0; m_ovf = 1'b0; m_serr = 1'b0;
            return;
        end
        rd = hit_rd && (nh > 0);
        if (digest_valid && act) begin
            if (nt > 0) begin
                pop_ok = 1'b1;
                popped = m_tags.pop_front();
            end else begin
                m_serr = 1'b1;
            end
        end
        if (cand_valid && m_phase == P_SCAN) begin
            if (nt < INFL || pop_ok) m_tags.push_back(cand_value);
            else m_serr = 1'b1;
        end
        if (rd) void'(m_hits.pop_front());
        if (pop_ok && digest == m_tgt) begin
            if (m_total < 65535) m_total++;
            if (nh < HDEPTH || rd) m_hits.push_back(popped);
            else m_ovf = 1'b1;
        end
        if (m_phase == P_SCAN && src_done) m_phase = P_DRAIN;
        else if (m_phase == P_DRAIN && nt == 0 && !digest_valid) m_phase = P_DONE;
    endtask

    task automatic check_outputs();
        logic [31:0] head;
        head = (m_hits.size() > 0) ? m_hits[0] : 32'd0;
        chk("hit_value", hit_value, head);
        chk("hit_empty", 32'(hit_empty), 32'(m_hits.size() == 0));
        chk("hit_total", 32'(hit_total), 32'(m_total));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("seq_err",   32'(seq_err),   32'(m_serr));
        chk("busy",      32'(busy),      32'(m_phase == P_SCAN || m_phase == P_DRAIN));
        chk("done",      32'(done),      32'(m_phase == P_DONE));
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic clr();
        reset = 1'b0; start = 1'b0; cand_valid = 1'b0; src_done = 1'b0;
        digest_valid = 1'b0; hit_rd = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        chk(tag, hit_value, exp);
        hit_rd = 1'b1;
        step();
        hit_rd = 1'b0;
    endtask

    initial begin
        logic [31:0]  drv[$];
        logic [31:0]  v;
        logic [127:0] t2;
        clr();
        target = '0; cand_value = '0; digest = '0;

        // Reset state
        reset = 1'b1;
        step(); step();
        clr();
        chk("rst_hit_empty", 32'(hit_empty), 32'd1);
        chk("rst_hit_value", hit_value, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        $display("[TB] reset checked");

        // 1: candidates 0..9, digests lag 3 cycles, target = digest of 5
        start = 1'b1; target = fmd5(32'd5); step(); clr();
        for (int c = 0; c < 13; c++) begin
            cand_valid = (c < 10); cand_value = 32'(c); src_done = (c == 9);
            digest_valid = (c >= 3); digest = fmd5(32'(c - 3));
            step();
        end
        clr();
        step();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_hit", hit_value, 32'd5);
        chk("t1_total", 32'(hit_total), 32'd1);
        $display("[TB] test1 single hit scan");

        // 2: five matches with no reads overflow a 4-deep hit FIFO
        t2 = 128'hDEADBEEF_00112233_44556677_8899AABB;
        start = 1'b1; target = t2; step(); clr();
        for (int c = 0; c < 8; c++) begin
            cand_valid = (c < 7); cand_value = 32'(c); src_done = (c == 6);
            digest_valid = (c >= 1);
            digest = (c - 1 >= 1 && c - 1 <= 5) ? t2 : fmd5(32'(c - 1));
            step();
        end
        clr();
        step(); step();
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_total", 32'(hit_total), 32'd5);
        for (int i = 1; i <= 4; i++) pop_expect("t2_pop", 32'(i));
        chk("t2_empty", 32'(hit_empty), 32'd1);
        $display("[TB] test2 hit overflow");

        // 3: stray digest sets seq_err; next start clears it
        start = 1'b1; target = fmd5(32'd3); step(); clr();
        digest_valid = 1'b1; digest = fmd5(32'd3); step(); clr();
        chk("t3_seq_err", 32'(seq_err), 32'd1);
        chk("t3_total", 32'(hit_total), 32'd0);
        src_done = 1'b1; step(); clr(); step(); step();
        start = 1'b1; target = fmd5(32'd110); step(); clr();
        chk("t3_seq_clr", 32'(seq_err), 32'd0);
        $display("[TB] test3 stray digest");

        // 4: 64 in flight, 65th dropped, then all retire in order
        for (int i = 0; i < 64; i++) begin
            cand_valid = 1'b1; cand_value = 32'(100 + i); step();
        end
        cand_value = 32'd164; step(); clr();
        chk("t4_seq_err", 32'(seq_err), 32'd1);
        src_done = 1'b1; step(); clr();
        for (int i = 0; i < 64; i++) begin
            digest_valid = 1'b1; digest = fmd5(32'(100 + i)); step();
        end
        clr();
        step();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_hit", hit_value, 32'd110);
        chk("t4_total", 32'(hit_total), 32'd1);
        $display("[TB] test4 in-flight limit");

        // 5: reset during DRAIN with 10 in flight
        start = 1'b1; target = fmd5(32'd0); step(); clr();
        for (int i = 0; i < 10; i++) begin
            cand_valid = 1'b1; cand_value = 32'(i); src_done = (i == 9); step();
        end
        clr();
        step();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1; step(); clr();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_hit_empty", 32'(hit_empty), 32'd1);
        for (int i = 0; i < 3; i++) begin
            digest_valid = 1'b1; digest = fmd5(32'(i)); step();
        end
        clr();
        chk("t5_total", 32'(hit_total), 32'd0);
        chk("t5_seq_err", 32'(seq_err), 32'd0);
        $display("[TB] test5 reset in drain");

        // 6: full hit FIFO, match and read in the same cycle
        start = 1'b1; target = t2; step(); clr();
        for (int c = 0; c < 5; c++) begin
            cand_valid = 1'b1; cand_value = 32'(c + 1);
            digest_valid = (c >= 1); digest = t2;
            step();
        end
        clr();
        digest_valid = 1'b1; digest = t2; hit_rd = 1'b1; src_done = 1'b1;
        step(); clr();
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_total", 32'(hit_total), 32'd5);
        for (int i = 2; i <= 5; i++) pop_expect("t6_pop", 32'(i));
        chk("t6_empty", 32'(hit_empty), 32'd1);
        step();
        $display("[TB] test6 full FIFO read-write");

        // Randomized scans against the model
        for (int s = 0; s < 6; s++) begin
            start = 1'b1; target = fmd5($urandom_range(0, 15)); step(); clr();
            drv.delete();
            for (int cyc = 0; cyc < 300; cyc++) begin
                digest_valid = 1'b0;
                if (drv.size() > 0 && ($urandom % 2) == 1) begin
                    digest_valid = 1'b1;
                    v = drv.pop_front();
                    digest = fmd5(v);
                end else if (drv.size() == 0 && ($urandom % 25) == 0) begin
                    digest_valid = 1'b1;
                    digest = {$urandom, $urandom, $urandom, $urandom};
                end
                cand_valid = (cyc < 150) && (drv.size() < 60) && (($urandom % 2) == 1);
                cand_value = $urandom_range(0, 15);
                if (cand_valid) drv.push_back(cand_value);
                src_done = (cyc == 149);
                hit_rd = (($urandom % 3) == 0);
                step();
            end
            clr();
            step(); step();
            $display("[TB] random scan %0d: hits=%0d seq_err=%0d", s, m_total, m_serr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
